// File: rtl/pll_reset_sequencer_if.sv
// Signal bundle between the PLL reset sequencer and the PLL / downstream core.
// The master modport is the sequencer; the slave modport is the PLL-and-core side.
interface pll_reset_sequencer_if;
    logic       pll_lock;
    logic       pll_resetb;
    logic       pll_bypass;
    logic       core_reset;
    logic       locked;
    logic [7:0] retry_count;
    logic       fault;

    modport master (
        input  pll_lock,
        output pll_resetb,
        output pll_bypass,
        output core_reset,
        output locked,
        output retry_count,
        output fault
    );

    modport slave (
        output pll_lock,
        input  pll_resetb,
        input  pll_bypass,
        input  core_reset,
        input  locked,
        input  retry_count,
        input  fault
    );
endinterface

// File: rtl/pll_reset_sequencer.sv
// Reset/lock supervisor for one iCE40 PLL, clocked by the PLL reference clock.
// Optional bypass fallback after repeated failures: define PLL_BYPASS_FALLBACK_EN.
module pll_reset_sequencer #(
    parameter int RESET_CYCLES  = 16,
    parameter int LOCK_TIMEOUT  = 4096,
    parameter int STABLE_CYCLES = 256,
    parameter int MAX_RETRIES   = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    pll_reset_sequencer_if.master  bus
);

    localparam int MAX_CYCLES_A = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_CYCLES   = (MAX_CYCLES_A > STABLE_CYCLES) ? MAX_CYCLES_A : STABLE_CYCLES;
    localparam int CW           = $clog2(MAX_CYCLES + 1);

    localparam logic [CW-1:0] RESET_LAST   = CW'(RESET_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);

    localparam logic [2:0] HOLD      = 3'd0;
    localparam logic [2:0] WAIT_LOCK = 3'd1;
    localparam logic [2:0] STABLE    = 3'd2;
    localparam logic [2:0] RUN       = 3'd3;
`ifdef PLL_BYPASS_FALLBACK_EN
    localparam logic [2:0] FAULT     = 3'd4;
    localparam logic [7:0] RETRY_LIMIT = 8'(MAX_RETRIES);
`endif

    logic          lock_meta;
    logic          lock_s;
    logic [2:0]    state;
    logic [2:0]    state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic [7:0]    retry;
    logic [7:0]    retry_next;
    logic          fail;
    logic          resetb_q;
    logic          core_reset_q;
    logic          locked_q;
    logic          resetb_next;
    logic          core_reset_next;
    logic          locked_next;

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        cnt_next   = cnt + 1'b1;
        retry_next = retry;
        fail       = 1'b0;

        case (state)
            HOLD: begin
                if (cnt == RESET_LAST) begin
                    state_next = WAIT_LOCK;
                    cnt_next   = '0;
                end
            end
            WAIT_LOCK: begin
                // A lock seen on the timeout cycle takes priority over the failure.
                if (lock_s) begin
                    state_next = STABLE;
                    cnt_next   = '0;
                end else if (cnt == TIMEOUT_LAST) begin
                    fail = 1'b1;
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    state_next = WAIT_LOCK;
                    cnt_next   = '0;
                end else if (cnt == STABLE_LAST) begin
                    state_next = RUN;
                    cnt_next   = '0;
                end
            end
            RUN: begin
                cnt_next = cnt;
                if (!lock_s) begin
                    fail = 1'b1;
                end
            end
`ifdef PLL_BYPASS_FALLBACK_EN
            FAULT: begin
                if (cnt == RESET_LAST) begin
                    cnt_next = cnt;
                end
            end
`endif
            default: begin
                state_next = HOLD;
                cnt_next   = '0;
            end
        endcase

        if (fail) begin
            retry_next = (retry == 8'hFF) ? retry : retry + 8'd1;
            cnt_next   = '0;
            state_next = HOLD;
`ifdef PLL_BYPASS_FALLBACK_EN
            if (retry_next == RETRY_LIMIT) begin
                state_next = FAULT;
            end
`endif
        end

        // Outputs are computed from the next state so they register on the same edge as it.
        resetb_next     = (state_next == WAIT_LOCK) || (state_next == STABLE) || (state_next == RUN);
        locked_next     = (state_next == RUN);
        core_reset_next = (state_next != RUN);
`ifdef PLL_BYPASS_FALLBACK_EN
        if (state_next == FAULT) begin
            core_reset_next = !((state == FAULT) && (cnt == RESET_LAST));
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lock_meta    <= 1'b0;
            lock_s       <= 1'b0;
            state        <= HOLD;
            cnt          <= '0;
            retry        <= 8'd0;
            resetb_q     <= 1'b0;
            core_reset_q <= 1'b1;
            locked_q     <= 1'b0;
        end else begin
            lock_meta    <= bus.pll_lock;
            lock_s       <= lock_meta;
            state        <= state_next;
            cnt          <= cnt_next;
            retry        <= retry_next;
            resetb_q     <= resetb_next;
            core_reset_q <= core_reset_next;
            locked_q     <= locked_next;
        end
    end

`ifdef PLL_BYPASS_FALLBACK_EN
    logic bypass_q;
    logic fault_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bypass_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            bypass_q <= (state_next == FAULT);
            fault_q  <= (state_next == FAULT);
        end
    end

    assign bus.pll_bypass = bypass_q;
    assign bus.fault      = fault_q;
`else
    assign bus.pll_bypass = 1'b0;
    assign bus.fault      = 1'b0;
`endif

    assign bus.pll_resetb  = resetb_q;
    assign bus.core_reset  = core_reset_q;
    assign bus.locked      = locked_q;
    assign bus.retry_count = retry;

endmodule
